// File: rtl/raycast_pkg.sv
// rtl/raycast_pkg.sv - shared types and constants for the raycast frame control path
package raycast_pkg;
    localparam int SCREEN_WIDTH_DEF  = 320;
    localparam int SCREEN_HEIGHT_DEF = 240;
    localparam int FIX_WIDTH         = 16;
    localparam int HCOUNT_WIDTH      = 9;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WAIT_SWAP
    } t_seq_state;
endpackage

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - ray column request handshake toward the DDA
interface frame_sequencer_if;
    import raycast_pkg::*;

    logic                    ray_valid_out;
    logic                    ray_ready_in;
    logic [HCOUNT_WIDTH-1:0] ray_hcount_out;
    logic                    ray_last_out;

    modport master (
        output ray_valid_out,
        output ray_hcount_out,
        output ray_last_out,
        input  ray_ready_in
    );

    modport slave (
        input  ray_valid_out,
        input  ray_hcount_out,
        input  ray_last_out,
        output ray_ready_in
    );
endinterface

// File: rtl/ray_column_issuer.sv
// rtl/ray_column_issuer.sv - valid/ready column counter, one request per screen column
module ray_column_issuer
    import raycast_pkg::*;
#(
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF
) (
    input  logic                    pixel_clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic                    ray_ready_in,
    output logic                    ray_valid_out,
    output logic [HCOUNT_WIDTH-1:0] ray_hcount_out,
    output logic                    ray_last_out,
    output logic                    done_out
);
    localparam logic [HCOUNT_WIDTH-1:0] LAST_COL = HCOUNT_WIDTH'(SCREEN_WIDTH - 1);

    logic                    active;
    logic [HCOUNT_WIDTH-1:0] hcount;
    logic                    at_last;

    assign at_last = (hcount == LAST_COL);

    // hcount only moves on an accepted transfer, so it is held while ready is low
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            active <= 1'b0;
            hcount <= '0;
        end else if (start_in) begin
            active <= 1'b1;
            hcount <= '0;
        end else if (active && ray_ready_in) begin
            if (at_last) begin
                active <= 1'b0;
                hcount <= '0;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    assign ray_valid_out  = active;
    assign ray_hcount_out = hcount;
    assign ray_last_out   = active && at_last;
    assign done_out       = active && ray_ready_in && at_last;
endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame raycast controller: camera latch, column issue, bank swap
module frame_sequencer
    import raycast_pkg::*;
#(
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
    parameter int POS_WIDTH    = FIX_WIDTH
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_in,
    input  logic                 enable_in,
    input  logic                 new_frame_in,
    input  logic [POS_WIDTH-1:0] pos_x_in,
    input  logic [POS_WIDTH-1:0] pos_y_in,
    input  logic [POS_WIDTH-1:0] dir_x_in,
    input  logic [POS_WIDTH-1:0] dir_y_in,
    input  logic [POS_WIDTH-1:0] plane_x_in,
    input  logic [POS_WIDTH-1:0] plane_y_in,
    input  logic                 ray_last_pixel_in,
    frame_sequencer_if.master    ray,
    output logic [POS_WIDTH-1:0] pos_x_out,
    output logic [POS_WIDTH-1:0] pos_y_out,
    output logic [POS_WIDTH-1:0] dir_x_out,
    output logic [POS_WIDTH-1:0] dir_y_out,
    output logic [POS_WIDTH-1:0] plane_x_out,
    output logic [POS_WIDTH-1:0] plane_y_out,
    output logic                 write_bank_out,
    output logic                 read_bank_out,
    output logic                 frame_done_out,
    output logic [7:0]           dropped_frames_out,
    output logic                 busy_out
);
    t_seq_state state, state_nxt;
    logic start, latch_cam, toggle_bank, drop_inc, done_pulse, issue_done;

    ray_column_issuer #(.SCREEN_WIDTH(SCREEN_WIDTH)) u_issuer (
        .pixel_clk_in  (pixel_clk_in),
        .rst_in        (rst_in),
        .start_in      (start),
        .ray_ready_in  (ray.ray_ready_in),
        .ray_valid_out (ray.ray_valid_out),
        .ray_hcount_out(ray.ray_hcount_out),
        .ray_last_out  (ray.ray_last_out),
        .done_out      (issue_done)
    );

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Every frame start (from IDLE or a boundary swap) latches the camera and kicks the issuer
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        latch_cam   = 1'b0;
        toggle_bank = 1'b0;
        drop_inc    = 1'b0;
        done_pulse  = 1'b0;
        unique case (state)
            IDLE: begin
                if (new_frame_in && enable_in) begin
                    start     = 1'b1;
                    latch_cam = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                drop_inc = new_frame_in;
                if (issue_done) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (ray_last_pixel_in) begin
                    done_pulse = 1'b1;
                    state_nxt  = WAIT_SWAP;
                    if (new_frame_in) begin
                        toggle_bank = 1'b1;
                        start       = enable_in;
                        latch_cam   = enable_in;
                        state_nxt   = enable_in ? ISSUE : IDLE;
                    end
                end else begin
                    drop_inc = new_frame_in;
                end
            end
            WAIT_SWAP: begin
                if (new_frame_in) begin
                    toggle_bank = 1'b1;
                    start       = enable_in;
                    latch_cam   = enable_in;
                    state_nxt   = enable_in ? ISSUE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            pos_x_out          <= '0;
            pos_y_out          <= '0;
            dir_x_out          <= '0;
            dir_y_out          <= '0;
            plane_x_out        <= '0;
            plane_y_out        <= '0;
            write_bank_out     <= 1'b0;
            frame_done_out     <= 1'b0;
            dropped_frames_out <= '0;
        end else begin
            frame_done_out <= done_pulse;
            if (latch_cam) begin
                pos_x_out   <= pos_x_in;
                pos_y_out   <= pos_y_in;
                dir_x_out   <= dir_x_in;
                dir_y_out   <= dir_y_in;
                plane_x_out <= plane_x_in;
                plane_y_out <= plane_y_in;
            end
            if (toggle_bank) write_bank_out <= ~write_bank_out;
            if (drop_inc && dropped_frames_out != 8'hFF)
                dropped_frames_out <= dropped_frames_out + 8'd1;
        end
    end

    assign read_bank_out = ~write_bank_out;
    assign busy_out      = (state == ISSUE) || (state == DRAIN);
endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed table and sequence bench for frame_sequencer
module tb_frame_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        en, nf, lp;
    logic [15:0] pos_x, pos_y, dir_x, dir_y, plane_x, plane_y;
    logic [15:0] pos_x_o, pos_y_o, dir_x_o, dir_y_o, plane_x_o, plane_y_o;
    logic        wb, rb, fd, busy;
    logic [7:0]  drop;

    int checks = 0;
    int errors = 0;

    frame_sequencer_if rif ();

    always #5 clk = ~clk;

    frame_sequencer #(.SCREEN_WIDTH(320), .POS_WIDTH(16)) dut (
        .pixel_clk_in      (clk),
        .rst_in            (rst),
        .enable_in         (en),
        .new_frame_in      (nf),
        .pos_x_in          (pos_x),
        .pos_y_in          (pos_y),
        .dir_x_in          (dir_x),
        .dir_y_in          (dir_y),
        .plane_x_in        (plane_x),
        .plane_y_in        (plane_y),
        .ray_last_pixel_in (lp),
        .ray               (rif.master),
        .pos_x_out         (pos_x_o),
        .pos_y_out         (pos_y_o),
        .dir_x_out         (dir_x_o),
        .dir_y_out         (dir_y_o),
        .plane_x_out       (plane_x_o),
        .plane_y_out       (plane_y_o),
        .write_bank_out    (wb),
        .read_bank_out     (rb),
        .frame_done_out    (fd),
        .dropped_frames_out(drop),
        .busy_out          (busy)
    );

    typedef struct {
        logic       nf, en, rdy, lp;
        logic       valid;
        logic [8:0] hc;
        logic       last, wb, busy, fd;
        logic [7:0] drop;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_full_row();
        rif.ray_ready_in = 1'b1;
        for (int k = 1; k <= 320; k++) begin
            step();
            if (k < 320) begin
                if (rif.ray_hcount_out !== 9'(k) || rif.ray_last_out !== (k == 319))
                    chk("row_hcount_last", {22'd0, rif.ray_last_out, rif.ray_hcount_out},
                        {22'd0, (k == 319), 9'(k)});
            end
        end
        chk("row_hcount_319_seen", 32'd1, 32'd1 & ~{31'd0, rif.ray_valid_out});
    endtask

    initial begin
        int exp_hc;
        int cyc;

        rst = 1'b1; en = 1'b0; nf = 1'b0; lp = 1'b0; rif.ray_ready_in = 1'b0;
        pos_x = 16'h0180; pos_y = 16'h0240; dir_x = 16'h0100; dir_y = 16'h0000;
        plane_x = 16'h0000; plane_y = 16'h00A8;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};

        #12;
        chk("rst_valid", {31'd0, rif.ray_valid_out}, 32'd0);
        chk("rst_banks", {30'd0, wb, rb}, 32'd1);
        chk("rst_drop_fd_busy", {22'd0, drop, fd, busy}, 32'd0);
        chk("rst_pos_x", {16'd0, pos_x_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // frame start, stalls, and drops while issuing
        for (int i = 0; i < 7; i++) begin
            nf = vecs[i].nf; en = vecs[i].en; rif.ray_ready_in = vecs[i].rdy; lp = vecs[i].lp;
            step();
            chk($sformatf("vec%0d_valid", i), {31'd0, rif.ray_valid_out}, {31'd0, vecs[i].valid});
            chk($sformatf("vec%0d_hcount", i), {23'd0, rif.ray_hcount_out}, {23'd0, vecs[i].hc});
            chk($sformatf("vec%0d_last", i), {31'd0, rif.ray_last_out}, {31'd0, vecs[i].last});
            chk($sformatf("vec%0d_wbank", i), {31'd0, wb}, {31'd0, vecs[i].wb});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            chk($sformatf("vec%0d_done", i), {31'd0, fd}, {31'd0, vecs[i].fd});
            chk($sformatf("vec%0d_drop", i), {24'd0, drop}, {24'd0, vecs[i].drop});
        end
        chk("latched_pos_y", {16'd0, pos_y_o}, 32'h0240);

        // random backpressure; camera change mid-frame must not reach the outputs
        pos_x = 16'h7777;
        exp_hc = 3;
        cyc = 0;
        while (exp_hc < 320 && cyc < 4000) begin
            rif.ray_ready_in = 1'($urandom_range(0, 1));
            if (rif.ray_ready_in) exp_hc++;
            step();
            cyc++;
            if (exp_hc < 320) begin
                if (rif.ray_valid_out !== 1'b1 || rif.ray_hcount_out !== 9'(exp_hc) ||
                    rif.ray_last_out !== (exp_hc == 319))
                    chk("bp_vld_hc_last", {21'd0, rif.ray_valid_out, rif.ray_last_out, rif.ray_hcount_out},
                        {21'd0, 1'b1, (exp_hc == 319), 9'(exp_hc)});
            end
        end
        chk("bp_transfer_count", exp_hc, 320);
        chk("bp_drain_valid", {31'd0, rif.ray_valid_out}, 32'd0);
        chk("bp_drain_busy", {31'd0, busy}, 32'd1);
        chk("midframe_pos_x_held", {16'd0, pos_x_o}, 32'h0180);

        // last pixel then a boundary: done pulse, bank swap, new camera
        rif.ray_ready_in = 1'b0;
        lp = 1'b1;
        step();
        chk("drain_done_pulse", {31'd0, fd}, 32'd1);
        chk("wait_swap_busy", {31'd0, busy}, 32'd0);
        lp = 1'b0;
        step();
        chk("done_one_cycle", {31'd0, fd}, 32'd0);
        chk("no_swap_yet", {31'd0, wb}, 32'd0);
        pos_x = 16'h0200; plane_y = 16'hFF00; en = 1'b1; nf = 1'b1;
        step();
        nf = 1'b0;
        chk("swap_banks", {30'd0, wb, rb}, 32'd2);
        chk("swap_start_hc", {22'd0, rif.ray_valid_out, rif.ray_hcount_out}, {22'd0, 1'b1, 9'd0});
        chk("swap_pos_x", {16'd0, pos_x_o}, 32'h0200);
        chk("swap_plane_y", {16'd0, plane_y_o}, 32'hFF00);
        chk("swap_drop_kept", {24'd0, drop}, 32'd3);

        // simultaneous last pixel and boundary while draining
        run_full_row();
        chk("drain2_busy", {31'd0, busy}, 32'd1);
        nf = 1'b1; lp = 1'b1;
        step();
        nf = 1'b0; lp = 1'b0;
        chk("simul_done", {31'd0, fd}, 32'd1);
        chk("simul_banks", {30'd0, wb, rb}, 32'd1);
        chk("simul_issue", {22'd0, rif.ray_valid_out, rif.ray_hcount_out}, {22'd0, 1'b1, 9'd0});
        chk("simul_no_drop", {24'd0, drop}, 32'd3);

        // asynchronous reset at hcount 150
        rif.ray_ready_in = 1'b1;
        for (int k = 0; k < 150; k++) step();
        chk("pre_rst_hc", {23'd0, rif.ray_hcount_out}, 32'd150);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid_hc", {22'd0, rif.ray_valid_out, rif.ray_hcount_out}, 32'd0);
        chk("arst_banks", {30'd0, wb, rb}, 32'd1);
        chk("arst_drop_busy", {23'd0, drop, busy}, 32'd0);
        chk("arst_pos_x", {16'd0, pos_x_o}, 32'd0);
        step();
        rst = 1'b0;
        rif.ray_ready_in = 1'b0;
        nf = 1'b1;
        step();
        nf = 1'b0;
        chk("post_rst_start", {22'd0, rif.ray_valid_out, rif.ray_hcount_out}, {22'd0, 1'b1, 9'd0});
        chk("post_rst_no_toggle", {31'd0, wb}, 32'd0);
        chk("post_rst_pos_x", {16'd0, pos_x_o}, 32'h0200);

        // drop counter saturation
        nf = 1'b1;
        for (int k = 0; k < 260; k++) step();
        nf = 1'b0;
        chk("drop_saturate", {24'd0, drop}, 32'd255);
        chk("drop_no_toggle", {31'd0, wb}, 32'd0);
        chk("drop_hc_held", {23'd0, rif.ray_hcount_out}, 32'd0);

        // disabled boundary drops to IDLE; IDLE ignores boundaries until enabled
        run_full_row();
        lp = 1'b1;
        step();
        lp = 1'b0;
        nf = 1'b1; en = 1'b0;
        step();
        chk("disable_swap", {30'd0, wb, busy}, 32'd2);
        chk("disable_idle_valid", {31'd0, rif.ray_valid_out}, 32'd0);
        step();
        chk("idle_ignore", {29'd0, wb, busy, rif.ray_valid_out}, 32'd4);
        en = 1'b1;
        step();
        nf = 1'b0;
        chk("idle_restart", {29'd0, wb, busy, rif.ray_valid_out}, 32'd7);
        chk("idle_restart_drop", {24'd0, drop}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
